// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA raster generator.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;
    localparam int POS_W  = 10;
    localparam int FCNT_W = 10;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    function automatic int axis_total(input int display, input int front,
                                      input int sync, input int back);
        return display + front + sync + back;
    endfunction
endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle: the generator drives it (master), colour stages consume it (slave).
interface vga_timing_if;
    import vga_timing_pkg::*;

    logic [POS_W-1:0]  hpos;
    logic [POS_W-1:0]  vpos;
    logic              hsync;
    logic              vsync;
    logic              display_on;
    logic              line_start;
    logic              frame_start;
    logic [FCNT_W-1:0] frame_count;

    modport master (output hpos, vpos, hsync, vsync, display_on,
                    line_start, frame_start, frame_count);
    modport slave  (input  hpos, vpos, hsync, vsync, display_on,
                    line_start, frame_start, frame_count);
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter plus registered active/sync decode of the next count.
// Latency 0 between pos_o and its flags; holds everything while adv_i is low.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int DISPLAY  = DEF_H_DISPLAY,
    parameter int FRONT    = DEF_H_FRONT,
    parameter int SYNC     = DEF_H_SYNC,
    parameter int BACK     = DEF_H_BACK,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv_i,
    output logic             wrap_o,
    output logic [POS_W-1:0] pos_o,
    output logic             active_o,
    output logic             sync_o
);
    localparam int               TOTAL      = axis_total(DISPLAY, FRONT, SYNC, BACK);
    localparam logic [POS_W-1:0] LAST       = POS_W'(TOTAL - 1);
    localparam int               SYNC_START = DISPLAY + FRONT;
    localparam int               SYNC_END   = DISPLAY + FRONT + SYNC;

    logic [POS_W-1:0] pos_q, pos_d;
    logic             active_q, active_d;
    logic             sync_q, sync_d;

    assign wrap_o = (pos_q == LAST);

    // Flags decode the next count so they land in the same cycle as pos_o.
    always_comb begin
        pos_d = pos_q;
        if (adv_i) begin
            pos_d = wrap_o ? '0 : pos_q + POS_W'(1);
        end
        active_d = (int'(pos_d) < DISPLAY);
        sync_d   = ((int'(pos_d) >= SYNC_START) && (int'(pos_d) < SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_q    <= LAST;
            active_q <= 1'b0;
            sync_q   <= ~SYNC_POL;
        end else begin
            pos_q    <= pos_d;
            active_q <= active_d;
            sync_q   <= sync_d;
        end
    end

    assign pos_o    = pos_q;
    assign active_o = active_q;
    assign sync_o   = sync_q;
endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator (hpos/vpos, syncs, display_on, strobes, frame counter); all flags coherent with position.
// Latency 0 from counters to flags; pix_en=0 holds all state and zeroes strobes. Macro VGA_TIMING_FRAME_CNT_EN enables frame_count.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY  = DEF_H_DISPLAY,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_DISPLAY  = DEF_V_DISPLAY,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pix_en,
    vga_timing_if.master vga
);
    localparam int H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    if (H_TOTAL > (1 << POS_W) || V_TOTAL > (1 << POS_W)) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    logic h_wrap, v_wrap, h_active, v_active;
    logic line_start_q, frame_start_q;

    vga_axis_counter #(
        .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .SYNC_POL(H_SYNC_POL)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .adv_i(pix_en), .wrap_o(h_wrap),
        .pos_o(vga.hpos), .active_o(h_active), .sync_o(vga.hsync)
    );

    vga_axis_counter #(
        .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .SYNC_POL(V_SYNC_POL)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .adv_i(pix_en & h_wrap), .wrap_o(v_wrap),
        .pos_o(vga.vpos), .active_o(v_active), .sync_o(vga.vsync)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= pix_en & h_wrap;
            frame_start_q <= pix_en & h_wrap & v_wrap;
        end
    end

    assign vga.display_on  = h_active & v_active;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              run_q, run_d;

    // The entry into (0,0) straight out of reset is not a completed frame, so it is not counted.
    always_comb begin
        run_d  = run_q | pix_en;
        fcnt_d = fcnt_q;
        if (run_q && pix_en && h_wrap && v_wrap) begin
            fcnt_d = fcnt_q + FCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fcnt_q <= '0;
            run_q  <= 1'b0;
        end else begin
            fcnt_q <= fcnt_d;
            run_q  <= run_d;
        end
    end

    assign vga.frame_count = fcnt_q;
`else
    assign vga.frame_count = '0;
`endif
endmodule
